// File: rtl/approx_err_pkg.sv
// ----------------------------------------------------------------------------
// approx_err_pkg
// Shared definitions for the approximate-adder error-metric engine:
//   state_t         FSM states of the controller
//   LFSR_TAPS       Galois feedback mask used by both operand generators
//   DEFAULT_SEED_*  power-on seeds for the operand A / operand B generators
//   safe_seed()     maps an all-zero seed (a dead LFSR state) to 1
//   lfsr_next()     one Galois step of the 32-bit generator
// ----------------------------------------------------------------------------
package approx_err_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED_A = 32'h1234_5678;
  localparam logic [31:0] DEFAULT_SEED_B = 32'h8765_4321;

  // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced by 1.
  function automatic logic [31:0] safe_seed(input logic [31:0] seed);
    return (seed == 32'd0) ? 32'd1 : seed;
  endfunction

  // Right-shifting Galois form: the bit shifted out of bit 0 decides whether
  // the tap mask is folded back into the shifted state.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : 32'd0);
  endfunction

endpackage

// File: rtl/lfsr32.sv
// ----------------------------------------------------------------------------
// lfsr32
// 32-bit Galois LFSR operand generator with seed reload and step enable.
// Ports:
//   clk    in   1      clock, state updates on rising edge
//   rst_n  in   1      asynchronous active-low reset, state returns to seed
//   load   in   1      reload the seed (has priority over step)
//   step   in   1      advance the sequence by one position
//   state  out  OUT_W  low OUT_W bits of the current 32-bit state
// ----------------------------------------------------------------------------
module lfsr32
  import approx_err_pkg::*;
#(
  parameter logic [31:0] SEED  = DEFAULT_SEED_A,
  parameter int          OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [OUT_W-1:0] state
);

  localparam logic [31:0] START = safe_seed(SEED);

  logic [31:0] q;

  // The full 32-bit register always steps, even when only a slice is
  // exported, so the sequence is independent of the operand width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= START;
    end else if (load) begin
      q <= START;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

  assign state = q[OUT_W-1:0];

endmodule

// File: rtl/approx_adder_err_ctrl.sv
// ----------------------------------------------------------------------------
// approx_adder_err_ctrl
// Error-metric engine for an external approximate adder. Two LFSRs produce
// operand pairs, the adder's combinational sum is compared with the exact
// N-bit sum, and error count, total error distance and maximum error
// distance are accumulated for the host to turn into ER / MED / NMED.
// Ports:
//   clk        in   1      clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      one-cycle pulse, begins a run from IDLE or DONE
//   abort      in   1      ends a run, keeps partial stats, no done pulse
//   num_vec    in   CNT_W  number of vectors, sampled with start
//   adder_a    out  N      registered operand A to the adder
//   adder_b    out  N      registered operand B to the adder
//   adder_s    in   N      combinational sum returned by the adder
//   busy       out  1      high in LOAD, RUN and DRAIN
//   done       out  1      one-cycle pulse on entry to DONE
//   vec_cnt    out  CNT_W  vectors accumulated so far
//   err_count  out  CNT_W  vectors whose sum differed from the exact sum
//   sum_ed     out  ACC_W  sum of error distances, saturating
//   max_ed     out  N      largest error distance seen
// ----------------------------------------------------------------------------
module approx_adder_err_ctrl
  import approx_err_pkg::*;
#(
  parameter int          N      = 16,
  parameter int          CNT_W  = 32,
  parameter int          ACC_W  = 48,
  parameter logic [31:0] SEED_A = DEFAULT_SEED_A,
  parameter logic [31:0] SEED_B = DEFAULT_SEED_B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vec,
  output logic [N-1:0]     adder_a,
  output logic [N-1:0]     adder_b,
  input  logic [N-1:0]     adder_s,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [N-1:0]     max_ed
);

  // The accumulator sum is formed one bit wider than both the accumulator
  // and a single error distance so the carry out signals saturation.
  localparam int SUM_W = ((ACC_W > N) ? ACC_W : N) + 1;

  state_t           state;
  logic [CNT_W-1:0] num_vec_q;
  logic [CNT_W-1:0] issued;
  logic [N-1:0]     lfsr_a;
  logic [N-1:0]     lfsr_b;
  logic             v1;
  logic             v2;
  logic [N-1:0]     s_q;
  logic [N-1:0]     exact_q;
  logic [N-1:0]     ed;
  logic [SUM_W-1:0] sum_wide;
  logic [ACC_W-1:0] sum_next;
  logic             in_run_states;
  logic             flush;
  logic             issue;
  logic             lfsr_load;

  // Abort only has an effect while a run is in progress; it also blocks the
  // issue and accumulation that would otherwise happen on the same edge.
  always_comb begin
    in_run_states = (state == LOAD) || (state == RUN) || (state == DRAIN);
    flush         = abort && in_run_states;
    issue         = (state == RUN) && !abort;
    lfsr_load     = (state == LOAD) && !abort;
  end

  lfsr32 #(
    .SEED  (SEED_A),
    .OUT_W (N)
  ) u_lfsr_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (issue),
    .state (lfsr_a)
  );

  lfsr32 #(
    .SEED  (SEED_B),
    .OUT_W (N)
  ) u_lfsr_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (issue),
    .state (lfsr_b)
  );

  // Controller. DRAIN leaves when no operand pair is still waiting to be
  // sampled; the last sample is accumulated on that same edge, so the stats
  // are final in the first DONE cycle, num_vec+3 cycles after LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      num_vec_q <= '0;
      issued    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            state     <= LOAD;
            num_vec_q <= num_vec;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          issued <= '0;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (num_vec_q == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            issued <= issued + CNT_W'(1);
            if (issued + CNT_W'(1) == num_vec_q) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!v1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Error distance is the unsigned magnitude of the difference between the
  // sampled approximate sum and the exact sum of the same operand pair.
  always_comb begin
    ed       = (s_q > exact_q) ? (s_q - exact_q) : (exact_q - s_q);
    sum_wide = SUM_W'(sum_ed) + SUM_W'(ed);
    sum_next = (|sum_wide[SUM_W-1:ACC_W]) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  end

  // Three-stage datapath: issue registers the operands, the next edge
  // samples the adder's sum together with the exact sum, and the edge after
  // that folds the error distance into the statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adder_a   <= '0;
      adder_b   <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      s_q       <= '0;
      exact_q   <= '0;
      vec_cnt   <= '0;
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else begin
      if (issue) begin
        adder_a <= lfsr_a;
        adder_b <= lfsr_b;
      end
      v1 <= issue;
      v2 <= v1 && !flush;
      if (v1) begin
        s_q     <= adder_s;
        exact_q <= adder_a + adder_b;
      end
      if (lfsr_load) begin
        vec_cnt   <= '0;
        err_count <= '0;
        sum_ed    <= '0;
        max_ed    <= '0;
      end else if (v2 && !flush) begin
        vec_cnt   <= vec_cnt + CNT_W'(1);
        err_count <= err_count + CNT_W'(ed != '0);
        sum_ed    <= sum_next;
        if (ed > max_ed) begin
          max_ed <= ed;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_adder_err_ctrl.sv
// ----------------------------------------------------------------------------
// tb_approx_adder_err_ctrl
// Drives the error-metric engine with several plug-in adder stubs (exact,
// exact plus offset, lower-part-OR approximation) and compares the held
// statistics and handshake timing with a reference model that walks the
// same seeded operand sequence with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_approx_adder_err_ctrl;

  localparam logic [31:0] TB_SEED_A = 32'h1234_5678;
  localparam logic [31:0] TB_SEED_B = 32'h8765_4321;
  localparam logic [31:0] TB_TAPS   = 32'h8020_0003;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] num_vec;
  logic [15:0] adder_a;
  logic [15:0] adder_b;
  logic [15:0] adder_s;
  logic        busy;
  logic        done;
  logic [31:0] vec_cnt;
  logic [31:0] err_count;
  logic [47:0] sum_ed;
  logic [15:0] max_ed;

  logic        start_s;
  logic [31:0] num_vec_s;
  logic [15:0] sat_a;
  logic [15:0] sat_b;
  logic [15:0] sat_s;
  logic        busy_s;
  logic        done_s;
  logic [31:0] vec_cnt_s;
  logic [31:0] err_count_s;
  logic [7:0]  sum_ed_s;
  logic [15:0] max_ed_s;

  int          stubMode;
  logic [15:0] stubOff;
  int          passCount;
  int          checkCount;

  // One step of the seeded operand sequence.
  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TB_TAPS) : (s >> 1);
  endfunction

  // Plug-in adders: 0 exact, 1 exact plus offset, 2 lower 7 bits OR-ed with
  // the carry into the upper part taken from the AND of bit 6.
  function automatic logic [15:0] refSum(input int mode, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] off);
    logic [15:0] r;
    logic [8:0]  hi;
    case (mode)
      1: r = a + b + off;
      2: begin
        hi = a[15:7] + b[15:7] + {8'd0, a[6] & b[6]};
        r  = {hi, a[6:0] | b[6:0]};
      end
      default: r = a + b;
    endcase
    return r;
  endfunction

  always_comb adder_s = refSum(stubMode, adder_a, adder_b, stubOff);
  assign sat_s = refSum(1, sat_a, sat_b, 16'd100);

  approx_adder_err_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .num_vec   (num_vec),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_s   (adder_s),
    .busy      (busy),
    .done      (done),
    .vec_cnt   (vec_cnt),
    .err_count (err_count),
    .sum_ed    (sum_ed),
    .max_ed    (max_ed)
  );

  approx_adder_err_ctrl #(.ACC_W(8)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_s),
    .abort     (1'b0),
    .num_vec   (num_vec_s),
    .adder_a   (sat_a),
    .adder_b   (sat_b),
    .adder_s   (sat_s),
    .busy      (busy_s),
    .done      (done_s),
    .vec_cnt   (vec_cnt_s),
    .err_count (err_count_s),
    .sum_ed    (sum_ed_s),
    .max_ed    (max_ed_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Walks the first n operand pairs from the seeds and accumulates the
  // statistics with a saturating accumulator of accW bits.
  task automatic modelRun(input int n, input int mode, input logic [15:0] off, input int accW,
                          output longint mErr, output longint mSum, output longint mMax);
    logic [31:0] la;
    logic [31:0] lb;
    longint      cap;
    int          s;
    int          ex;
    int          ed;
    la   = TB_SEED_A;
    lb   = TB_SEED_B;
    cap  = (longint'(1) << accW) - 1;
    mErr = 0;
    mSum = 0;
    mMax = 0;
    for (int i = 0; i < n; i++) begin
      s  = int'(refSum(mode, la[15:0], lb[15:0], off));
      ex = (int'(la[15:0]) + int'(lb[15:0])) % 65536;
      ed = (s > ex) ? s - ex : ex - s;
      if (ed != 0) mErr++;
      mSum = mSum + ed;
      if (mSum > cap) mSum = cap;
      if (ed > mMax) mMax = ed;
      la = lfsrStep(la);
      lb = lfsrStep(lb);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a run of n vectors and watches it until done, counting busy
  // cycles; a start pulse is injected at cycle busyStartAt (0 = LOAD cycle).
  task automatic applyStimulus(input int n, input int busyStartAt,
                               output int doneAt, output int busyCyc);
    int k;
    @(negedge clk);
    start   = 1'b1;
    num_vec = n;
    @(negedge clk);
    start   = 1'b0;
    k       = 0;
    doneAt  = -1;
    busyCyc = 0;
    while (k <= n + 20) begin
      if (busy === 1'b1) busyCyc++;
      if (done === 1'b1) begin
        doneAt = k;
        break;
      end
      start = (k == busyStartAt);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input int n, input int mode,
                             input logic [15:0] off, input int busyStartAt);
    int     doneAt;
    int     busyCyc;
    longint eErr;
    longint eSum;
    longint eMax;
    stubMode = mode;
    stubOff  = off;
    applyStimulus(n, busyStartAt, doneAt, busyCyc);
    modelRun(n, mode, off, 48, eErr, eSum, eMax);
    checkOutput({tag, ".doneAt"}, doneAt, (n == 0) ? 1 : n + 3);
    checkOutput({tag, ".busyCycles"}, busyCyc, (n == 0) ? 1 : n + 3);
    checkOutput({tag, ".vec_cnt"}, vec_cnt, n);
    checkOutput({tag, ".err_count"}, err_count, eErr);
    checkOutput({tag, ".sum_ed"}, sum_ed, eSum);
    checkOutput({tag, ".max_ed"}, max_ed, eMax);
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, done, 0);
    checkOutput({tag, ".held_err"}, err_count, eErr);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          k;
    int          nRand;
    int          modeRand;
    int          donePulses;
    int          busySeen;
    int          partial;
    longint      eErr;
    longint      eSum;
    longint      eMax;
    logic [31:0] heldCnt;

    passCount  = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    num_vec    = '0;
    start_s    = 1'b0;
    num_vec_s  = '0;
    stubMode   = 0;
    stubOff    = '0;

    #23;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.stats", {vec_cnt, err_count}, 0);
    checkOutput("reset.sum_max", {sum_ed, max_ed}, 0);
    checkOutput("reset.operands", {adder_a, adder_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] exact adder, 1000 vectors, start pulse while busy");
    runAndCheck("exact", 1000, 0, 16'd0, 500);

    $display("[TB] sum plus one, 256 vectors");
    runAndCheck("plus1", 256, 1, 16'd1, -1);

    $display("[TB] lower-part-OR approximation, 3000 vectors");
    runAndCheck("loa", 3000, 2, 16'd0, 37);

    $display("[TB] zero vectors with start during LOAD");
    runAndCheck("zero", 0, 2, 16'd0, 0);

    for (int r = 0; r < 3; r++) begin
      nRand    = $urandom_range(300, 30);
      modeRand = $urandom_range(2, 0);
      $display("[TB] random run %0d: n=%0d mode=%0d", r, nRand, modeRand);
      runAndCheck($sformatf("rand%0d", r), nRand, modeRand, 16'($urandom), $urandom_range(20, 5));
    end

    $display("[TB] asynchronous reset in the middle of a run");
    stubMode = 2;
    @(negedge clk);
    start   = 1'b1;
    num_vec = 1000;
    @(negedge clk);
    start = 1'b0;
    k     = 0;
    while (vec_cnt < 50 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rst.reached50", vec_cnt >= 50, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst.busy_done", {busy, done}, 0);
    checkOutput("rst.stats", {vec_cnt, err_count}, 0);
    checkOutput("rst.sum_max", {sum_ed, max_ed}, 0);
    checkOutput("rst.operands", {adder_a, adder_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    runAndCheck("rerun", 1000, 2, 16'd0, -1);

    $display("[TB] abort in RUN together with start");
    stubMode = 2;
    @(negedge clk);
    start   = 1'b1;
    num_vec = 500;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort      = 1'b0;
    start      = 1'b0;
    heldCnt    = vec_cnt;
    donePulses = 0;
    busySeen   = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) donePulses++;
      if (busy === 1'b1) busySeen++;
    end
    checkOutput("abort.donePulses", donePulses, 0);
    checkOutput("abort.busyCycles", busySeen, 0);
    checkOutput("abort.vec_cnt_held", vec_cnt, heldCnt);
    checkOutput("abort.partial_range", (vec_cnt > 0) && (vec_cnt < 500), 1);
    partial = int'(vec_cnt);
    modelRun(partial, 2, 16'd0, 48, eErr, eSum, eMax);
    checkOutput("abort.err_count", err_count, eErr);
    checkOutput("abort.sum_ed", sum_ed, eSum);
    checkOutput("abort.max_ed", max_ed, eMax);
    runAndCheck("postAbort", 40, 1, 16'($urandom_range(9, 1)), 10);

    $display("[TB] 8-bit accumulator saturation, sum plus 100");
    @(negedge clk);
    start_s   = 1'b1;
    num_vec_s = 10;
    @(negedge clk);
    start_s = 1'b0;
    k       = 0;
    while (done_s !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    modelRun(10, 1, 16'd100, 8, eErr, eSum, eMax);
    checkOutput("sat.doneAt", k, 13);
    checkOutput("sat.vec_cnt", vec_cnt_s, 10);
    checkOutput("sat.err_count", err_count_s, eErr);
    checkOutput("sat.sum_ed", sum_ed_s, eSum);
    checkOutput("sat.max_ed", max_ed_s, eMax);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
